// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the five-stage RV32 pipeline.
// Merges hazard stall requests, sequences multi-cycle EXE ops and defers redirects across MEM stalls.
//
//   state   | meaning
//   IDLE    | no multi-cycle op in flight; redirects and op starts are accepted
//   MC_WAIT | multi-cycle op in flight; mc_cnt holds the remaining stall cycles
module pipe_ctrl #(
    parameter int MC_CNT_WIDTH = 6,
    parameter int PC_WIDTH     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    id_stallreq_i,
    input  logic                    exe_mc_start_i,
    input  logic [MC_CNT_WIDTH-1:0] exe_mc_cycles_i,
    input  logic                    mem_stallreq_i,
    input  logic                    exe_jump_i,
    input  logic [PC_WIDTH-1:0]     exe_jump_addr_i,
    output logic [4:0]              stall_o,
    output logic                    flush_o,
    output logic                    pc_redirect_o,
    output logic [PC_WIDTH-1:0]     new_pc_o,
    output logic                    mc_busy_o,
    output logic                    mc_done_o
);

    typedef enum logic {IDLE, MC_WAIT} state_t;

    localparam logic [4:0] STALL_ID  = 5'b00011;
    localparam logic [4:0] STALL_EXE = 5'b00111;
    localparam logic [4:0] STALL_MEM = 5'b01111;

    state_t                  state, state_nxt;
    logic [MC_CNT_WIDTH-1:0] mc_cnt, mc_cnt_nxt;
    logic                    jpend, jpend_nxt;
    logic [PC_WIDTH-1:0]     jpend_addr, jpend_addr_nxt;

    logic                    exe_stall;
    logic                    redirect;
    logic                    busy;
    logic                    done;
    logic [PC_WIDTH-1:0]     target;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            mc_cnt     <= '0;
            jpend      <= 1'b0;
            jpend_addr <= '0;
        end else begin
            state      <= state_nxt;
            mc_cnt     <= mc_cnt_nxt;
            jpend      <= jpend_nxt;
            jpend_addr <= jpend_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        mc_cnt_nxt     = mc_cnt;
        jpend_nxt      = jpend;
        jpend_addr_nxt = jpend_addr;
        exe_stall      = 1'b0;
        redirect       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        target         = '0;

        case (state)
            IDLE: begin
                // A latched redirect belongs to the instruction still in EXE, so a live jump is ignored
                if (jpend && !mem_stallreq_i) begin
                    redirect  = 1'b1;
                    target    = jpend_addr;
                    jpend_nxt = 1'b0;
                end else if (exe_jump_i && !mem_stallreq_i) begin
                    redirect = 1'b1;
                    target   = exe_jump_addr_i;
                end else if (exe_jump_i && mem_stallreq_i && !jpend) begin
                    jpend_nxt      = 1'b1;
                    jpend_addr_nxt = exe_jump_addr_i;
                end

                if (exe_mc_start_i && !exe_jump_i) begin
                    exe_stall = 1'b1;
                    if (exe_mc_cycles_i <= MC_CNT_WIDTH'(1)) begin
                        done = 1'b1;
                    end else begin
                        busy       = 1'b1;
                        mc_cnt_nxt = exe_mc_cycles_i - MC_CNT_WIDTH'(1);
                        state_nxt  = MC_WAIT;
                    end
                end
            end
            MC_WAIT: begin
                exe_stall  = 1'b1;
                busy       = 1'b1;
                mc_cnt_nxt = mc_cnt - MC_CNT_WIDTH'(1);
                if (mc_cnt <= MC_CNT_WIDTH'(1)) begin
                    done       = 1'b1;
                    mc_cnt_nxt = '0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even if requests are still asserted
    always_comb begin
        stall_o       = '0;
        flush_o       = 1'b0;
        pc_redirect_o = 1'b0;
        new_pc_o      = '0;
        mc_busy_o     = 1'b0;
        mc_done_o     = 1'b0;
        if (!rst_i) begin
            if (id_stallreq_i && !redirect) stall_o = stall_o | STALL_ID;
            if (exe_stall)                  stall_o = stall_o | STALL_EXE;
            if (mem_stallreq_i)             stall_o = stall_o | STALL_MEM;
            flush_o       = redirect;
            pc_redirect_o = redirect;
            new_pc_o      = target;
            mc_busy_o     = busy;
            mc_done_o     = done;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios followed by random traffic,
// compared every cycle against a cycle-count/pending-jump reference model.
module tb_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_stallreq_i;
    logic        exe_mc_start_i;
    logic [5:0]  exe_mc_cycles_i;
    logic        mem_stallreq_i;
    logic        exe_jump_i;
    logic [31:0] exe_jump_addr_i;
    logic [4:0]  stall_o;
    logic        flush_o;
    logic        pc_redirect_o;
    logic [31:0] new_pc_o;
    logic        mc_busy_o;
    logic        mc_done_o;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model: remaining exe stall cycles (0 = no op) and pending jump
    int          mc_left = 0;
    bit          jp      = 1'b0;
    logic [31:0] jpa     = '0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.MC_CNT_WIDTH(6), .PC_WIDTH(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_stallreq_i   (id_stallreq_i),
        .exe_mc_start_i  (exe_mc_start_i),
        .exe_mc_cycles_i (exe_mc_cycles_i),
        .mem_stallreq_i  (mem_stallreq_i),
        .exe_jump_i      (exe_jump_i),
        .exe_jump_addr_i (exe_jump_addr_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .pc_redirect_o   (pc_redirect_o),
        .new_pc_o        (new_pc_o),
        .mc_busy_o       (mc_busy_o),
        .mc_done_o       (mc_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input logic r, input logic id, input logic st, input logic [5:0] n,
                        input logic mem, input logic jmp, input logic [31:0] a);
        logic [4:0]  e_stall;
        logic        e_rd, e_busy, e_done, exe_st;
        logic [31:0] e_pc;
        rst_i = r; id_stallreq_i = id; exe_mc_start_i = st; exe_mc_cycles_i = n;
        mem_stallreq_i = mem; exe_jump_i = jmp; exe_jump_addr_i = a;
        #2;
        if (r) begin mc_left = 0; jp = 1'b0; jpa = '0; end
        e_stall = '0; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; exe_st = 1'b0; e_pc = '0;
        if (!r) begin
            if (mc_left > 0) begin
                exe_st = 1'b1; e_busy = 1'b1; e_done = (mc_left == 1);
            end else begin
                if (jp && !mem) begin e_rd = 1'b1; e_pc = jpa; end
                else if (jmp && !mem) begin e_rd = 1'b1; e_pc = a; end
                if (!jmp && st) begin
                    exe_st = 1'b1;
                    if (n <= 1) e_done = 1'b1; else e_busy = 1'b1;
                end
            end
            if (mem)              e_stall = 5'b01111;
            else if (exe_st)      e_stall = 5'b00111;
            else if (id && !e_rd) e_stall = 5'b00011;
        end
        chk("stall",    32'(stall_o),       32'(e_stall));
        chk("flush",    32'(flush_o),       32'(e_rd));
        chk("redirect", 32'(pc_redirect_o), 32'(e_rd));
        chk("new_pc",   new_pc_o,           e_pc);
        chk("busy",     32'(mc_busy_o),     32'(e_busy));
        chk("done",     32'(mc_done_o),     32'(e_done));
        @(posedge clk_i);
        if (!r) begin
            if (mc_left > 0) mc_left--;
            else begin
                if (jp && !mem) jp = 1'b0;
                else if (jmp && mem && !jp) begin jp = 1'b1; jpa = a; end
                if (!jmp && st && n >= 2) mc_left = int'(n) - 1;
            end
        end
        #1;
    endtask

    initial begin
        // reset, then reset mid-op (N=5, reset at t+2 with start still held)
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 5, 1, 1, 32'h44);
        step(0, 0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_idle_stall", 32'(stall_o), 32'd0);
        // load-use single cycle
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // multi-cycle N=4, then N=0 and N=1
        step(0, 0, 1, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // N=3 overlapped with mem stall t+1..t+4
        step(0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // jump masks load-use stall
        step(0, 1, 0, 0, 0, 1, 32'h0000_0100);
        // deferred jump across 3 mem stall cycles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 32'h0000_2000);
        step(0, 0, 0, 0, 0, 1, 32'h0000_2000);
        step(0, 0, 0, 0, 0, 0, 0);
        // jump wins over simultaneous start
        step(0, 0, 1, 6, 0, 1, 32'h0000_0300);
        step(0, 0, 0, 0, 0, 0, 0);
        // pending jump discarded by reset
        step(0, 0, 0, 0, 1, 1, 32'h0000_0500);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 6'($urandom_range(0, 9)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0),
                 {$urandom} & 32'hFFFF_FFFC);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
